timer16: RTL and testbench

//  16-bit down-counting timer peripheral on the CPU bus, decoded at $FB10-$FB1F (ce from top-level decode).
//  8-bit prescaler generates ticks; counter reloads or stops at zero, sets an overflow flag, and drives
//  the CPU interrupt input (active-low). Sits beside pio on the same bus: it consumes CPU writes and

---
 rtl/timer16_if.sv | 20 ++
 rtl/timer16.sv | 156 +++++++++++++++
 tb/tb_timer16.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer16_if.sv
// CPU-side register bus for the timer16 peripheral: decode enable, strobes,
// register offset and the two data paths.
interface timer16_if;
    logic       ce;
    logic       wren;
    logic       rden;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output ce, wren, rden, addr, data_in,
        input  data_out
    );

    modport slave (
        input  ce, wren, rden, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/timer16.sv
// 16-bit down-counting timer with 8-bit prescaler, auto-reload or one-shot mode,
// sticky overflow flag and active-low interrupt, mapped as 16 byte registers.
module timer16 #(
    parameter logic [7:0]  PRESC_RST  = 8'hFF,
    parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
    input  logic      clk,
    input  logic      rst_n,
    timer16_if.slave  bus,
    output logic      irq_n,
    output logic      ovf_pulse
);

    localparam logic [3:0] A_CTRL     = 4'h0;
    localparam logic [3:0] A_PRESC    = 4'h1;
    localparam logic [3:0] A_RELOAD_L = 4'h2;
    localparam logic [3:0] A_RELOAD_H = 4'h3;
    localparam logic [3:0] A_COUNT_L  = 4'h4;
    localparam logic [3:0] A_COUNT_H  = 4'h5;
    localparam logic [3:0] A_STATUS   = 4'h6;

    logic        en_r;
    logic        auto_r;
    logic        irq_en_r;
    logic [7:0]  presc_r;
    logic [7:0]  presc_cnt_r;
    logic [15:0] reload_r;
    logic [15:0] count_r;
    logic [7:0]  shadow_r;
    logic        ovf_r;
    logic        ovf_pulse_r;

    logic        wr_s;
    logic        rd_s;
    logic        wr_ctrl_s;
    logic        wr_presc_s;
    logic        wr_rel_l_s;
    logic        wr_rel_h_s;
    logic        wr_status_s;
    logic        rd_count_l_s;
    logic        tick_s;
    logic        underflow_s;
    logic        en_rise_s;

    assign wr_s         = bus.ce & bus.wren;
    assign rd_s         = bus.ce & bus.rden;
    assign wr_ctrl_s    = wr_s & (bus.addr == A_CTRL);
    assign wr_presc_s   = wr_s & (bus.addr == A_PRESC);
    assign wr_rel_l_s   = wr_s & (bus.addr == A_RELOAD_L);
    assign wr_rel_h_s   = wr_s & (bus.addr == A_RELOAD_H);
    assign wr_status_s  = wr_s & (bus.addr == A_STATUS);
    assign rd_count_l_s = rd_s & (bus.addr == A_COUNT_L);

    assign tick_s      = en_r & (presc_cnt_r == 8'h00);
    // A RELOAD_H write on the tick edge takes priority, so it also suppresses underflow.
    assign underflow_s = tick_s & (count_r == 16'h0000) & ~wr_rel_h_s;
    assign en_rise_s   = wr_ctrl_s & bus.data_in[0] & ~en_r;

    // Control, prescaler and reload registers written by the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
            presc_r  <= PRESC_RST;
            reload_r <= RELOAD_RST;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= bus.data_in[0];
                auto_r   <= bus.data_in[1];
                irq_en_r <= bus.data_in[2];
            end else if (underflow_s && !auto_r) begin
                en_r <= 1'b0;
            end
            if (wr_presc_s) begin
                presc_r <= bus.data_in;
            end
            if (wr_rel_l_s) begin
                reload_r[7:0] <= bus.data_in;
            end
            if (wr_rel_h_s) begin
                reload_r[15:8] <= bus.data_in;
            end
        end
    end

    // Prescaler and main down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= PRESC_RST;
            count_r     <= RELOAD_RST;
        end else begin
            if (wr_rel_h_s || en_rise_s) begin
                presc_cnt_r <= presc_r;
            end else if (tick_s) begin
                presc_cnt_r <= presc_r;
            end else if (en_r) begin
                presc_cnt_r <= presc_cnt_r - 8'd1;
            end

            if (wr_rel_h_s) begin
                count_r <= {bus.data_in, reload_r[7:0]};
            end else if (tick_s) begin
                if (count_r != 16'h0000) begin
                    count_r <= count_r - 16'd1;
                end else if (auto_r) begin
                    count_r <= reload_r;
                end else begin
                    count_r <= 16'h0000;
                end
            end
        end
    end

    // Overflow flag, underflow pulse and COUNT_H shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r       <= 1'b0;
            ovf_pulse_r <= 1'b0;
            shadow_r    <= 8'h00;
        end else begin
            if (underflow_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && bus.data_in[0]) begin
                ovf_r <= 1'b0;
            end
            ovf_pulse_r <= underflow_s;
            if (rd_count_l_s) begin
                shadow_r <= count_r[15:8];
            end
        end
    end

    assign irq_n     = ~(ovf_r & irq_en_r);
    assign ovf_pulse = ovf_pulse_r;

    // Register read mux; idle bus reads as zero.
    always_comb begin
        bus.data_out = 8'h00;
        if (rd_s) begin
            case (bus.addr)
                A_CTRL:     bus.data_out = {5'b00000, irq_en_r, auto_r, en_r};
                A_PRESC:    bus.data_out = presc_r;
                A_RELOAD_L: bus.data_out = reload_r[7:0];
                A_RELOAD_H: bus.data_out = reload_r[15:8];
                A_COUNT_L:  bus.data_out = count_r[7:0];
                A_COUNT_H:  bus.data_out = shadow_r;
                A_STATUS:   bus.data_out = {7'b0000000, ovf_r};
                default:    bus.data_out = 8'h00;
            endcase
        end else begin
            bus.data_out = 8'h00;
        end
    end

endmodule

// File: tb/tb_timer16.sv
// Scoreboard bench for timer16: expectations are queued as stimulus is driven
// and popped when the matching DUT output is sampled.
module tb_timer16;

    logic clk = 1'b0;
    logic rst_n;
    logic irq_n;
    logic ovf_pulse;

    timer16_if bus ();

    timer16 #(
        .PRESC_RST  (8'hFF),
        .RELOAD_RST (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .irq_n     (irq_n),
        .ovf_pulse (ovf_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.tag = "sb_empty";
            e.val = ~obs;
        end
        check_val(e.tag, obs, e.val);
    endtask

    // Called at a negedge; the write commits on the following posedge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.ce      = 1'b1;
        bus.wren    = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        @(negedge clk);
        bus.ce   = 1'b0;
        bus.wren = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string tag, input logic [7:0] exp);
        sb_push(tag, {8'h00, exp});
        bus.ce   = 1'b1;
        bus.rden = 1'b1;
        bus.addr = a;
        #1;
        sb_check({8'h00, bus.data_out});
        @(negedge clk);
        bus.ce   = 1'b0;
        bus.rden = 1'b0;
    endtask

    task automatic chk_sig(input string tag, input logic obs, input logic exp);
        sb_push(tag, {15'h0000, exp});
        sb_check({15'h0000, obs});
    endtask

    // Negedges until ovf_pulse is seen, or -1 when the limit runs out.
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while (ovf_pulse !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (ovf_pulse !== 1'b1) begin
            n = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rexp;

        rst_n       = 1'b0;
        bus.ce      = 1'b0;
        bus.wren    = 1'b0;
        bus.rden    = 1'b0;
        bus.addr    = 4'h0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset image of all 16 offsets (COUNT_L read first fills the shadow).
        chk_sig("rst_irq_n", irq_n, 1'b1);
        chk_sig("rst_ovf_pulse", ovf_pulse, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rexp = (i >= 1 && i <= 5) ? 8'hFF : 8'h00;
            rd(4'(i), $sformatf("rst_reg%0h", i), rexp);
        end

        // Auto-reload, PRESC=3, RELOAD=4: underflow every 20 clocks.
        wr(4'h1, 8'h03);
        wr(4'h2, 8'h04);
        wr(4'h3, 8'h00);
        wr(4'h0, 8'h07);
        wait_pulse(40, n);
        check_val("auto_first_period", 16'(n), 16'd20);
        chk_sig("auto_irq_low", irq_n, 1'b0);
        @(negedge clk);
        chk_sig("auto_pulse_width", ovf_pulse, 1'b0);
        wait_pulse(40, n);
        check_val("auto_second_period", 16'(n + 1), 16'd20);
        wr(4'h6, 8'h01);
        chk_sig("status_clear_irq", irq_n, 1'b1);
        wr(4'h0, 8'h00);
        rd(4'h6, "status_after_clear", 8'h00);

        // One-shot, PRESC=0, RELOAD=2.
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h02);
        wr(4'h3, 8'h00);
        wr(4'h0, 8'h01);
        wait_pulse(10, n);
        check_val("oneshot_delay", 16'(n), 16'd3);
        rd(4'h0, "oneshot_ctrl", 8'h00);
        rd(4'h4, "oneshot_cnt_l", 8'h00);
        rd(4'h5, "oneshot_cnt_h", 8'h00);
        rd(4'h6, "oneshot_status", 8'h01);
        chk_sig("oneshot_irq_masked", irq_n, 1'b1);
        wr(4'h6, 8'h01);

        // Atomic 16-bit read across the 0x0100 -> 0x00FF borrow.
        wr(4'h2, 8'h00);
        wr(4'h3, 8'h01);
        wr(4'h0, 8'h01);
        rd(4'h4, "shadow_cnt_l", 8'h00);
        rd(4'h5, "shadow_cnt_h", 8'h01);
        rd(4'h4, "shadow_live_l", 8'hFE);
        wr(4'h0, 8'h00);

        // STATUS clear on the exact underflow edge keeps OVF set.
        wr(4'h2, 8'h02);
        wr(4'h3, 8'h00);
        wr(4'h6, 8'h01);
        wr(4'h0, 8'h01);
        repeat (2) @(negedge clk);
        wr(4'h6, 8'h01);
        chk_sig("collide_pulse", ovf_pulse, 1'b1);
        rd(4'h6, "collide_status", 8'h01);
        wr(4'h6, 8'h01);
        rd(4'h6, "status_clear2", 8'h00);

        // RELOAD_H write on a tick edge loads without decrementing.
        wr(4'h1, 8'h03);
        wr(4'h2, 8'h10);
        wr(4'h3, 8'h00);
        wr(4'h0, 8'h01);
        repeat (3) @(negedge clk);
        wr(4'h3, 8'h00);
        rd(4'h4, "relh_tick_cnt_l", 8'h10);
        wr(4'h0, 8'h00);

        // Async reset while the interrupt is asserted.
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h03);
        wr(4'h3, 8'h00);
        wr(4'h0, 8'h07);
        wait_pulse(10, n);
        check_val("pre_reset_delay", 16'(n), 16'd4);
        chk_sig("pre_reset_irq", irq_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_sig("async_irq_n", irq_n, 1'b1);
        chk_sig("async_pulse", ovf_pulse, 1'b0);
        bus.ce   = 1'b1;
        bus.rden = 1'b1;
        bus.addr = 4'h0;
        sb_push("async_ctrl", 16'h0000);
        #1;
        sb_check({8'h00, bus.data_out});
        bus.addr = 4'h4;
        sb_push("async_cnt_l", 16'h00FF);
        #1;
        sb_check({8'h00, bus.data_out});
        bus.ce   = 1'b0;
        bus.rden = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'h6, "post_reset_status", 8'h00);
        rd(4'h3, "post_reset_rel_h", 8'hFF);

        check_val("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
